jtdd_vtiming: RTL and testbench



---
 rtl/jtdd_vtiming.sv | 128 ++++++++++++
 tb/tb_jtdd_vtiming.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_vtiming.sv
// Video timing generator: H/V dump counters, blank/sync, look-ahead render line
// and NIRQ raster-compare interrupt channels with sticky flags.
module jtdd_vtiming #(
    parameter int HW         = 9,
    parameter int VW         = 9,
    parameter int HCNT_START = 0,
    parameter int HCNT_END   = 383,
    parameter int HB_START   = 256,
    parameter int HB_END     = 0,
    parameter int HS_START   = 300,
    parameter int HS_END     = 332,
    parameter int VCNT_START = 0,
    parameter int VCNT_END   = 271,
    parameter int VB_START   = 240,
    parameter int VB_END     = 16,
    parameter int VS_START   = 250,
    parameter int VS_END     = 253,
    parameter int NIRQ       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_pxl_cen,
    output logic [HW-1:0]        o_hdump,
    output logic [VW-1:0]        o_vdump,
    output logic [VW-1:0]        o_vrender,
    output logic                 o_lhbl,
    output logic                 o_lvbl,
    output logic                 o_hs,
    output logic                 o_vs,
    input  logic [NIRQ*VW-1:0]   i_irq_line,
    input  logic [NIRQ-1:0]      i_irq_en,
    input  logic [NIRQ-1:0]      i_irq_ack,
    output logic [NIRQ-1:0]      o_irq
);

    localparam logic [HW-1:0] H_START  = HW'(HCNT_START);
    localparam logic [HW-1:0] H_END    = HW'(HCNT_END);
    localparam logic [HW-1:0] HB_S     = HW'(HB_START);
    localparam logic [HW-1:0] HB_E     = HW'(HB_END);
    localparam logic [HW-1:0] HS_S     = HW'(HS_START);
    localparam logic [HW-1:0] HS_E     = HW'(HS_END);
    localparam logic [VW-1:0] V_START  = VW'(VCNT_START);
    localparam logic [VW-1:0] V_END    = VW'(VCNT_END);
    localparam logic [VW-1:0] V_RENDER0 = VW'(VCNT_START + 1);
    localparam logic [VW-1:0] VB_S     = VW'(VB_START);
    localparam logic [VW-1:0] VB_E     = VW'(VB_END);
    localparam logic [VW-1:0] VS_S     = VW'(VS_START);
    localparam logic [VW-1:0] VS_E     = VW'(VS_END);

    // Equal start/end pairs would leave an output stuck; reject at elaboration.
    if (HCNT_START == HCNT_END || HB_START == HB_END || HS_START == HS_END ||
        VCNT_START == VCNT_END || VB_START == VB_END || VS_START == VS_END ||
        NIRQ < 1 || NIRQ > 8) begin : g_param_err
        $error("jtdd_vtiming: illegal timing parameters");
    end

    logic [HW-1:0]   r_hdump;
    logic [VW-1:0]   r_vdump;
    logic [VW-1:0]   r_vrender;
    logic            r_lhbl;
    logic            r_lvbl;
    logic            r_hs;
    logic            r_vs;
    logic [NIRQ-1:0] r_irq;
    logic            w_wrap;
    logic [HW-1:0]   w_hnext;

    function automatic logic [VW-1:0] f_vsucc(input logic [VW-1:0] v);
        return (v == V_END) ? V_START : v + VW'(1);
    endfunction

    assign w_wrap  = (r_hdump == H_END);
    assign w_hnext = w_wrap ? H_START : r_hdump + HW'(1);

    // Blank/sync compare against the incoming hdump so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdump   <= H_START;
            r_vdump   <= V_START;
            r_vrender <= V_RENDER0;
            r_lhbl    <= 1'b0;
            r_lvbl    <= 1'b0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
        end else if (i_pxl_cen) begin
            r_hdump <= w_hnext;
            if (w_wrap) begin
                r_vdump   <= r_vrender;
                r_vrender <= f_vsucc(r_vrender);
                if (r_vrender == VB_S)      r_lvbl <= 1'b0;
                else if (r_vrender == VB_E) r_lvbl <= 1'b1;
            end
            if (w_hnext == HB_S)      r_lhbl <= 1'b0;
            else if (w_hnext == HB_E) r_lhbl <= 1'b1;
            if (w_hnext == HS_S)      r_hs <= 1'b1;
            else if (w_hnext == HS_E) r_hs <= 1'b0;
            if (w_hnext == HS_S) begin
                if (r_vdump == VS_S)      r_vs <= 1'b1;
                else if (r_vdump == VS_E) r_vs <= 1'b0;
            end
        end
    end

    // r_vrender is always in range, so out-of-range compare lines never match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= '0;
        end else begin
            for (int i = 0; i < NIRQ; i++) begin
                if (i_pxl_cen && w_wrap && i_irq_en[i] &&
                    r_vrender == i_irq_line[i*VW +: VW])
                    r_irq[i] <= 1'b1;
                else if (i_irq_ack[i])
                    r_irq[i] <= 1'b0;
            end
        end
    end

    assign o_hdump   = r_hdump;
    assign o_vdump   = r_vdump;
    assign o_vrender = r_vrender;
    assign o_lhbl    = r_lhbl;
    assign o_lvbl    = r_lvbl;
    assign o_hs      = r_hs;
    assign o_vs      = r_vs;
    assign o_irq     = r_irq;

endmodule

// File: tb/tb_jtdd_vtiming.sv
// Directed bench: a default-parameter instance for reset, line timing and hold,
// and a shrunken-frame instance for whole-frame and interrupt behaviour.
module tb_jtdd_vtiming;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen_d = 1'b0;
    logic cen_s = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]  d_h, d_v, d_vr, s_h, s_v, s_vr;
    logic        d_lhbl, d_lvbl, d_hs, d_vs, s_lhbl, s_lvbl, s_hs, s_vs;
    logic [17:0] d_line, s_line;
    logic [1:0]  d_en, d_ack, d_irq, s_en, s_ack, s_irq;

    jtdd_vtiming dut (
        .clk(clk), .rst_n(rst_n), .i_pxl_cen(cen_d),
        .o_hdump(d_h), .o_vdump(d_v), .o_vrender(d_vr),
        .o_lhbl(d_lhbl), .o_lvbl(d_lvbl), .o_hs(d_hs), .o_vs(d_vs),
        .i_irq_line(d_line), .i_irq_en(d_en), .i_irq_ack(d_ack), .o_irq(d_irq)
    );

    // 24 pixels x 32 lines: HB 16..23, HS 18..19, VB 28..31+0..3, VS on line 29
    jtdd_vtiming #(
        .HCNT_END(23), .HB_START(16), .HB_END(0), .HS_START(18), .HS_END(20),
        .VCNT_END(31), .VB_START(28), .VB_END(4), .VS_START(29), .VS_END(30)
    ) sml (
        .clk(clk), .rst_n(rst_n), .i_pxl_cen(cen_s),
        .o_hdump(s_h), .o_vdump(s_v), .o_vrender(s_vr),
        .o_lhbl(s_lhbl), .o_lvbl(s_lvbl), .o_hs(s_hs), .o_vs(s_vs),
        .i_irq_line(s_line), .i_irq_en(s_en), .i_irq_ack(s_ack), .o_irq(s_irq)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_d(input int n);
        cen_d = 1'b1;
        repeat (n) tick();
        cen_d = 1'b0;
    endtask

    task automatic run_s(input int n);
        cen_s = 1'b1;
        repeat (n) tick();
        cen_s = 1'b0;
    endtask

    initial begin
        int n_lhbl, n_hs, n_lvbl, n_vs, changed, vrbad, drop, seen, fh, fv, irq1_hi;
        logic [31:0] exp_vr;

        d_line = {9'd0, 9'd10};
        d_en   = 2'b01;
        d_ack  = 2'b00;
        s_line = {9'd0, 9'd8};
        s_en   = 2'b01;
        s_ack  = 2'b00;

        // reset state
        repeat (2) tick();
        chk("rst_hdump", 32'(d_h), 0);
        chk("rst_vdump", 32'(d_v), 0);
        chk("rst_vrender", 32'(d_vr), 1);
        chk("rst_blank_sync", 32'({d_lhbl, d_lvbl, d_hs, d_vs}), 0);
        chk("rst_irq", 32'(d_irq), 0);
        rst_n = 1'b1;
        tick();

        // run to hdump=100, vdump=50; irq[0] was set at line 10
        run_d(50 * 384 + 100);
        chk("mid_hdump", 32'(d_h), 100);
        chk("mid_vdump", 32'(d_v), 50);
        chk("mid_vrender", 32'(d_vr), 51);
        chk("mid_blank_sync", 32'({d_lhbl, d_lvbl, d_hs, d_vs}), 32'b1100);
        chk("mid_irq", 32'(d_irq), 1);

        // asynchronous reset mid-frame, checked between clock edges
        cen_d = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_hdump", 32'(d_h), 0);
        chk("async_rst_vdump", 32'(d_v), 0);
        chk("async_rst_vrender", 32'(d_vr), 1);
        chk("async_rst_blank_sync", 32'({d_lhbl, d_lvbl, d_hs, d_vs}), 0);
        chk("async_rst_irq", 32'(d_irq), 0);
        rst_n = 1'b1;
        tick();
        chk("release_hdump", 32'(d_h), 1);
        chk("release_vdump", 32'(d_v), 0);
        repeat (383) tick();
        cen_d = 1'b0;
        chk("line1_hdump", 32'(d_h), 0);
        chk("line1_vdump", 32'(d_v), 1);

        // one full line with pxl_cen every 4 clk
        n_lhbl = 0;
        n_hs = 0;
        for (int k = 0; k < 384; k++) begin
            cen_d = 1'b1;
            tick();
            cen_d = 1'b0;
            if (d_lhbl === 1'b0) n_lhbl++;
            if (d_hs === 1'b1) n_hs++;
            repeat (3) tick();
        end
        chk("line_lhbl_low", n_lhbl, 128);
        chk("line_hs_high", n_hs, 32);
        chk("line2_hdump", 32'(d_h), 0);
        chk("line2_vdump", 32'(d_v), 2);

        // hold with pxl_cen low at hdump=200
        run_d(200);
        changed = 0;
        repeat (1000) begin
            tick();
            if ({d_h, d_v, d_vr, d_lhbl, d_lvbl, d_hs, d_vs} !== {9'd200, 9'd2, 9'd3, 4'b1000})
                changed++;
        end
        chk("hold_changes", changed, 0);
        chk("hold_hdump", 32'(d_h), 200);
        chk("hold_blank_sync", 32'({d_lhbl, d_lvbl, d_hs, d_vs}), 32'b1000);
        run_d(1);
        chk("resume_hdump", 32'(d_h), 201);

        // small frame: two frames at 1 pxl per 4 clk, measure the second
        n_lhbl = 0; n_hs = 0; n_lvbl = 0; n_vs = 0;
        vrbad = 0; drop = 0; seen = 0; fh = -1; fv = -1;
        for (int k = 1; k <= 1536; k++) begin
            cen_s = 1'b1;
            tick();
            cen_s = 1'b0;
            if (k > 768) begin
                if (s_lhbl === 1'b0) n_lhbl++;
                if (s_hs === 1'b1) n_hs++;
                if (s_lvbl === 1'b0) n_lvbl++;
                if (s_vs === 1'b1) n_vs++;
            end
            exp_vr = (s_v == 9'd31) ? 0 : 32'(s_v) + 1;
            if (32'(s_vr) !== exp_vr) vrbad++;
            if (seen == 0 && s_irq[0] === 1'b1) begin
                seen = 1;
                fh = int'(s_h);
                fv = int'(s_v);
            end else if (seen == 1 && s_irq[0] !== 1'b1) begin
                drop++;
            end
            repeat (3) tick();
        end
        chk("frame_lhbl_low", n_lhbl, 8 * 32);
        chk("frame_hs_high", n_hs, 2 * 32);
        chk("frame_lvbl_low", n_lvbl, 8 * 24);
        chk("frame_vs_high", n_vs, 24);
        chk("frame_vrender", vrbad, 0);
        chk("frame_end_pos", 32'({s_v, s_h}), 0);
        chk("irq_first_hdump", fh, 0);
        chk("irq_first_vdump", fv, 8);
        chk("irq_sticky", drop, 0);

        // acknowledge on a clk edge without pxl_cen
        s_ack = 2'b01;
        tick();
        s_ack = 2'b00;
        chk("ack_clears", 32'(s_irq), 0);

        // set and ack on the same edge: set wins
        run_s(7 * 24 + 23);
        s_ack = 2'b01;
        cen_s = 1'b1;
        tick();
        cen_s = 1'b0;
        s_ack = 2'b00;
        chk("set_ack_pos", 32'({s_v, s_h}), 32'({9'd8, 9'd0}));
        chk("set_wins", 32'(s_irq), 1);

        // both channels on line 20, only channel 0 enabled
        s_ack = 2'b11;
        tick();
        s_ack = 2'b00;
        chk("ack_both", 32'(s_irq), 0);
        s_line = {9'd20, 9'd20};
        s_en = 2'b01;
        run_s(12 * 24);
        chk("en_mask", 32'(s_irq), 1);
        s_en = 2'b00;
        tick();
        chk("en_off_keeps_flag", 32'(s_irq), 1);

        // channel 1 on a line beyond the frame never fires
        s_line = {9'd40, 9'd20};
        s_en = 2'b11;
        s_ack = 2'b01;
        tick();
        s_ack = 2'b00;
        irq1_hi = 0;
        cen_s = 1'b1;
        repeat (768) begin
            tick();
            if (s_irq[1] !== 1'b0) irq1_hi++;
        end
        cen_s = 1'b0;
        chk("out_of_range_never", irq1_hi, 0);
        chk("ch0_refires", 32'(s_irq), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
